// File: rtl/md_unit_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: opcode encodings,
// operation width, default latencies, FSM state type and decode helpers.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB accumulate ops).
package md_unit_ctrl_pkg;

  localparam int unsigned MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd8;
  localparam logic [MD_OP_W-1:0] MD_MSUB  = 4'd9;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MD_ST_IDLE = 1'b0,
    MD_ST_RUN  = 1'b1
  } md_state_e;

  // Ops that occupy the unit for multiple cycles and commit to HI/LO.
  function automatic logic md_is_long_op(input logic [MD_OP_W-1:0] op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic md_is_div_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_ctrl_datapath.sv
// md_datapath: combinational multiply/divide arithmetic. Produces the
// {hi,lo} value to commit for the latched op and flags divide by zero.
// Optional feature macro: MDU_MADD_EN adds the accumulate input and adder.
module md_datapath
  import md_unit_ctrl_pkg::*;
(
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  input  logic [MD_OP_W-1:0] op,
`ifdef MDU_MADD_EN
  input  logic [63:0]        acc,
`endif
  output logic [63:0]        hilo_next,
  output logic               div_by_zero
);

  logic        signed_mul;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;

  logic        signed_div;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] den;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // One 64x64 multiplier; signedness chosen by operand extension, the
  // low 64 bits of the product are exact in both cases.
  always_comb begin
    signed_mul = (op == MD_MULT);
`ifdef MDU_MADD_EN
    signed_mul = signed_mul || (op == MD_MADD) || (op == MD_MSUB);
`endif
    mul_a = signed_mul ? {{32{a[31]}}, a} : {32'b0, a};
    mul_b = signed_mul ? {{32{b[31]}}, b} : {32'b0, b};
    prod  = mul_a * mul_b;
  end

  // Sign-magnitude division: avoids the signed-overflow corner of
  // 0x80000000 / -1, which falls out as quotient 0x80000000, remainder 0.
  always_comb begin
    signed_div  = (op == MD_DIV);
    neg_a       = signed_div & a[31];
    neg_b       = signed_div & b[31];
    mag_a       = neg_a ? (32'd0 - a) : a;
    mag_b       = neg_b ? (32'd0 - b) : b;
    div_by_zero = md_is_div_op(op) && (b == '0);
    den         = (b == '0) ? 32'd1 : mag_b;
    q_mag       = mag_a / den;
    r_mag       = mag_a % den;
    quot        = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    rem         = neg_a ? (32'd0 - r_mag) : r_mag;
  end

  // Select the commit value for the latched op.
  always_comb begin
    hilo_next = '0;
    case (op)
      MD_MULT, MD_MULTU: hilo_next = prod;
      MD_DIV, MD_DIVU:   hilo_next = {rem, quot};
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU: hilo_next = acc + prod;
      MD_MSUB:           hilo_next = acc - prod;
`endif
      default:           hilo_next = '0;
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multi-cycle multiply/divide sequencer owning HI/LO.
// Holds the FSM, latency counter, operand latches and HI/LO registers;
// arithmetic lives in md_datapath.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB accumulate ops).
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [31:0]        A,
  input  logic [31:0]        B,
  output logic               busy,
  output logic [31:0]        hi,
  output logic [31:0]        lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [MD_OP_W-1:0] op_q, op_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic [63:0]        hilo_next;
  logic               div_by_zero;

  md_datapath u_datapath (
    .a           (a_q),
    .b           (b_q),
    .op          (op_q),
`ifdef MDU_MADD_EN
    .acc         ({hi_q, lo_q}),
`endif
    .hilo_next   (hilo_next),
    .div_by_zero (div_by_zero)
  );

  // Next-state: accept requests in IDLE, count down in RUN, commit at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MD_ST_IDLE: begin
        if (start) begin
          if (md_is_long_op(md_op)) begin
            a_d     = A;
            b_d     = B;
            op_d    = md_op;
            state_d = MD_ST_RUN;
            busy_d  = 1'b1;
            cnt_d   = md_is_div_op(md_op) ? CNT_W'(DIV_CYCLES - 1)
                                          : CNT_W'(MULT_CYCLES - 1);
          end else if (md_op == MD_MTHI) begin
            hi_d = A;
          end else if (md_op == MD_MTLO) begin
            lo_d = A;
          end
        end
      end
      MD_ST_RUN: begin
        if (cnt_q == '0) begin
          state_d = MD_ST_IDLE;
          busy_d  = 1'b0;
          if (!div_by_zero) begin
            {hi_d, lo_d} = hilo_next;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = MD_ST_IDLE;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= MD_NONE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed cases with literal
// expectations plus a randomized run against a behavioural model.
// Honours MDU_MADD_EN the same way the design does.
module tb_md_unit_ctrl;
  import md_unit_ctrl_pkg::*;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  md_unit_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int unsigned latency_of(input logic [3:0] op);
    case (op)
      MD_MULT, MD_MULTU: return MULT_N;
      MD_DIV, MD_DIVU:   return DIV_N;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB: return MULT_N;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] acc);
    int          ia, ib, iq, ir;
    longint      la, lb, sp;
    logic [63:0] up;
    ia = a;
    ib = b;
    la = ia;
    lb = ib;
    sp = la * lb;
    up = {32'b0, a} * {32'b0, b};
    case (op)
      MD_MULT:  return sp;
      MD_MULTU: return up;
      MD_DIV: begin
        if (b == 0) return acc;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        iq = ia / ib;
        ir = ia % ib;
        return {ir, iq};
      end
      MD_DIVU: begin
        if (b == 0) return acc;
        return {a % b, a / b};
      end
`ifdef MDU_MADD_EN
      MD_MADD:  return acc + sp;
      MD_MADDU: return acc + up;
      MD_MSUB:  return acc - sp;
`endif
      default:  return acc;
    endcase
  endfunction

  // Inputs as seen by the DUT at each rising edge.
  logic        s_reset, s_start;
  logic [3:0]  s_op;
  logic [31:0] s_a, s_b;
  always @(posedge clk) begin
    s_reset <= reset;
    s_start <= start;
    s_op    <= md_op;
    s_a     <= A;
    s_b     <= B;
  end

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int unsigned m_left = 0;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b;

  // Advance the model by the edge just taken, then compare mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (s_reset) begin
        m_hi = '0; m_lo = '0; m_left = 0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) {m_hi, m_lo} = model_result(m_op, m_a, m_b, {m_hi, m_lo});
      end else if (s_start) begin
        if (latency_of(s_op) > 0) begin
          m_left = latency_of(s_op);
          m_op = s_op; m_a = s_a; m_b = s_b;
        end else if (s_op == MD_MTHI) begin
          m_hi = s_a;
        end else if (s_op == MD_MTLO) begin
          m_lo = s_a;
        end
      end
      check32("model_busy", {31'b0, busy}, {31'b0, (m_left > 0)});
      check32("model_hi", hi, m_hi);
      check32("model_lo", lo, m_lo);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; A = a; B = b;
    tick();
    start = 1'b0; md_op = MD_NONE; A = $urandom; B = $urandom;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] pick_op();
    if ($urandom_range(0, 1) == 0) return 4'($urandom_range(1, 4));
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit expired");
    finish_run();
  end

  initial begin
    reset = 1'b1; start = 1'b0; md_op = MD_NONE; A = '0; B = '0;
    tick(); tick();
    check32("rst_busy", {31'b0, busy}, 32'd0);
    check32("rst_hi", hi, 32'd0);
    check32("rst_lo", lo, 32'd0);
    reset = 1'b0;
    tick();

    // MULT -2 * 3
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    check32("mult_busy_first", {31'b0, busy}, 32'd1);
    repeat (4) tick();
    check32("mult_busy_last", {31'b0, busy}, 32'd1);
    tick();
    check32("mult_busy_done", {31'b0, busy}, 32'd0);
    check32("mult_hi", hi, 32'hFFFF_FFFF);
    check32("mult_lo", lo, 32'hFFFF_FFFA);

    // DIV -7 / 2, then DIVU same operands
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (9) tick();
    check32("div_busy_last", {31'b0, busy}, 32'd1);
    tick();
    check32("div_busy_done", {31'b0, busy}, 32'd0);
    check32("div_lo", lo, 32'hFFFF_FFFD);
    check32("div_hi", hi, 32'hFFFF_FFFF);
    issue(MD_DIVU, 32'hFFFF_FFF9, 32'd2);
    repeat (10) tick();
    check32("divu_lo", lo, 32'h7FFF_FFFC);
    check32("divu_hi", hi, 32'h0000_0001);

    // Overflow corner
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (10) tick();
    check32("divovf_lo", lo, 32'h8000_0000);
    check32("divovf_hi", hi, 32'h0000_0000);

    // MTHI then MTLO back to back, then DIVU by zero
    start = 1'b1; md_op = MD_MTHI; A = 32'h1234_5678;
    tick();
    check32("mthi_hi", hi, 32'h1234_5678);
    check32("mthi_busy", {31'b0, busy}, 32'd0);
    md_op = MD_MTLO; A = 32'h9ABC_DEF0;
    tick();
    start = 1'b0; md_op = MD_NONE;
    check32("mtlo_lo", lo, 32'h9ABC_DEF0);
    check32("mtlo_hi", hi, 32'h1234_5678);
    check32("mtlo_busy", {31'b0, busy}, 32'd0);
    issue(MD_DIVU, 32'd55, 32'd0);
    repeat (9) tick();
    check32("div0_busy_last", {31'b0, busy}, 32'd1);
    tick();
    check32("div0_busy_done", {31'b0, busy}, 32'd0);
    check32("div0_hi", hi, 32'h1234_5678);
    check32("div0_lo", lo, 32'h9ABC_DEF0);

    // Starts while busy are ignored; start as busy falls is accepted
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    tick();
    start = 1'b1; md_op = MD_DIV; A = 32'd100; B = 32'd3;
    tick();
    md_op = MD_MTHI; A = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; md_op = MD_NONE;
    tick();
    check32("ign_busy_last", {31'b0, busy}, 32'd1);
    tick();
    check32("ign_busy_done", {31'b0, busy}, 32'd0);
    check32("ign_hi", hi, 32'h0000_0001);
    check32("ign_lo", lo, 32'hFFFF_FFFE);
    issue(MD_DIVU, 32'd100, 32'd7);
    check32("b2b_busy", {31'b0, busy}, 32'd1);
    repeat (9) tick();
    check32("b2b_busy_last", {31'b0, busy}, 32'd1);
    tick();
    check32("b2b_lo", lo, 32'd14);
    check32("b2b_hi", hi, 32'd2);

    // Reset in the 4th busy cycle aborts the divide
    issue(MD_DIV, 32'd100, 32'd3);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check32("abort_busy", {31'b0, busy}, 32'd0);
    check32("abort_hi", hi, 32'd0);
    check32("abort_lo", lo, 32'd0);
    repeat (12) tick();
    check32("abort_hi_late", hi, 32'd0);
    check32("abort_lo_late", lo, 32'd0);

    // Accumulate op
    start = 1'b1; md_op = MD_MTHI; A = 32'd0;
    tick();
    md_op = MD_MTLO; A = 32'hFFFF_FFFF;
    tick();
    start = 1'b0; md_op = MD_NONE;
    issue(MD_MADDU, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    check32("maddu_busy", {31'b0, busy}, 32'd1);
    repeat (5) tick();
    check32("maddu_hi", hi, 32'd1);
    check32("maddu_lo", lo, 32'd0);
`else
    check32("maddu_busy", {31'b0, busy}, 32'd0);
    repeat (5) tick();
    check32("maddu_hi", hi, 32'd0);
    check32("maddu_lo", lo, 32'hFFFF_FFFF);
`endif

    // Randomized run checked by the model process
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      start = ($urandom_range(0, 1) == 0);
      md_op = pick_op();
      A     = pick_val();
      B     = pick_val();
      tick();
    end
    reset = 1'b0; start = 1'b0; md_op = MD_NONE;
    repeat (DIV_N + 2) tick();
    finish_run();
  end

endmodule
